// File: rtl/sine_pkg.sv
// Shared constants for the quarter-wave sine: widths, full scale and the coarse knot table.
// Knots are generated at elaboration from a fixed-point Taylor series, so no literal table to mistype.
package sine_pkg;

    localparam int IN_W      = 13;
    localparam int OUT_W     = 16;
    localparam int AMP       = 32767;
    localparam int SEG_BITS  = 7;
    localparam int SEG_N     = 1 << SEG_BITS;
    localparam int FRAC_BITS = IN_W - SEG_BITS;
    localparam int TAB_F     = 8;
    localparam int TAB_W     = 24;

    // pi/2 in Q30
    localparam longint HALF_PI_Q30 = 64'sd1686629713;

    typedef logic [SEG_N:0][TAB_W-1:0] tab_t;

    function automatic longint sin_q30(input longint x);
        longint x2;
        longint term;
        longint acc;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        return acc;
    endfunction

    // Knot k sits at code 64k, i.e. angle (pi/2)(64k + 0.5)/8192; value kept with TAB_F fraction bits.
    function automatic tab_t build_tab();
        tab_t   t;
        longint x;
        longint s;
        for (int k = 0; k <= SEG_N; k++) begin
            x = (HALF_PI_Q30 * longint'(2 * k * (1 << FRAC_BITS) + 1)) >>> (IN_W + 1);
            s = sin_q30(x);
            t[(SEG_BITS+1)'(k)] = TAB_W'((longint'(AMP) * s + (longint'(1) <<< (29 - TAB_F))) >>> (30 - TAB_F));
        end
        return t;
    endfunction

    localparam tab_t SINE_TAB = build_tab();

endpackage

// File: rtl/sine_quarter_rom.sv
// Coarse sine table: segment index -> knot value and slope to the next knot (TAB_F fraction bits).
// Latency: combinational.
// Backpressure: none; pure lookup.
module sine_quarter_rom
    import sine_pkg::*;
(
    input  logic [SEG_BITS-1:0] seg,
    output logic [TAB_W-1:0]    base,
    output logic [TAB_W-1:0]    slope
);

    localparam int IDX_W = SEG_BITS + 1;

    logic [IDX_W-1:0] idx;
    logic [TAB_W-1:0] next_val;

    always_comb begin
        idx      = {1'b0, seg};
        base     = SINE_TAB[idx];
        next_val = SINE_TAB[idx + IDX_W'(1)];
        // The table is monotone rising, so the difference never goes negative.
        slope    = next_val - base;
    end

endmodule

// File: rtl/sine_quarter_lut.sv
// First-quadrant sine magnitude: coarse knots plus linear interpolation, rounded and clamped to AMP.
// Latency: 1 cycle, one result per cycle.
// Backpressure: none; a new phase index is accepted every clock.
module sine_quarter_lut #(
    parameter int IN_W  = sine_pkg::IN_W,
    parameter int OUT_W = sine_pkg::OUT_W,
    parameter int AMP   = sine_pkg::AMP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  v,
    output logic [OUT_W-1:0] sv
);

    localparam int SEG_BITS  = sine_pkg::SEG_BITS;
    localparam int TAB_W     = sine_pkg::TAB_W;
    localparam int TAB_F     = sine_pkg::TAB_F;
    localparam int FRAC_BITS = IN_W - SEG_BITS;
    localparam int SHIFT     = FRAC_BITS + TAB_F;
    localparam int ACC_W     = TAB_W + FRAC_BITS + 1;
    localparam int MAG_W     = ACC_W - SHIFT;

    localparam logic [ACC_W-1:0] HALF  = ACC_W'(1) << (SHIFT - 1);
    localparam logic [MAG_W-1:0] AMP_M = MAG_W'(AMP);

    logic [TAB_W-1:0] base;
    logic [TAB_W-1:0] slope;
    logic [ACC_W-1:0] acc;
    logic [MAG_W-1:0] mag;
    logic [OUT_W-1:0] f_v;

    sine_quarter_rom u_rom (
        .seg   (v[IN_W-1 -: SEG_BITS]),
        .base  (base),
        .slope (slope)
    );

    // Product and sum stay at full width; only the final rounded shift drops bits.
    always_comb begin
        acc = {1'b0, base, {FRAC_BITS{1'b0}}} + ACC_W'(slope) * ACC_W'(v[FRAC_BITS-1:0]);
        mag = MAG_W'((acc + HALF) >> SHIFT);
        f_v = (mag > AMP_M) ? OUT_W'(AMP) : OUT_W'(mag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= '0;
        end else begin
            sv <= f_v;
        end
    end

endmodule

// File: tb/tb_sine_quarter_lut.sv
// Directed and exhaustive checks of the quarter-wave sine against the ideal rounded sine.
module tb_sine_quarter_lut;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] v;
    logic [15:0] sv;
    logic [31:0] phase;
    logic [12:0] folded;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          prev;
    int          cur;

    sine_quarter_lut #(
        .IN_W  (13),
        .OUT_W (16),
        .AMP   (32767)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .v     (v),
        .sv    (sv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp, input int tol);
        n_cmp++;
        if (got > exp + tol || got < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int ideal(input int code);
        real ang;
        ang = 3.14159265358979 * (real'(code) + 0.5) / 16384.0;
        return $rtoi($floor(32767.0 * $sin(ang) + 0.5));
    endfunction

    task automatic drive(input logic [12:0] code);
        @(negedge clk);
        v = code;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        v     = 13'd8191;
        #1;
        chk("rst_async", int'(sv), 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", int'(sv), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Endpoints and interior points; S(v) includes the half-code offset.
        drive(13'd0);    chk("v0",    int'(sv), 3,     2);
        drive(13'd8191); chk("v8191", int'(sv), 32767, 0);
        drive(13'd2048); chk("v2048", int'(sv), 12542, 2);
        drive(13'd6144); chk("v6144", int'(sv), 30274, 2);
        drive(13'd4096); chk("v4096", int'(sv), 23172, 2);
        drive(13'd100);  chk("v100",  int'(sv), 631,   2);
        drive(13'd8091); chk("v8091", int'(sv), 32761, 2);

        // Back-to-back alternation, no bubbles.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) begin
                drive(13'd8191);
                chk("alt_hi", int'(sv), 32767, 0);
            end else begin
                drive(13'd0);
                chk("alt_lo", int'(sv), 3, 2);
            end
        end

        // Caller-side fold: quadrant 1 uses the complement of phase[29:17].
        phase  = 32'h4000_0000;
        folded = phase[30] ? ~phase[29:17] : phase[29:17];
        drive(folded);
        chk("fold_q1", int'(sv), 32767, 0);

        // Mid-stream reset discards the pending value and clears sv at once.
        drive(13'd6144);
        chk("pre_rst", int'(sv), 30274, 2);
        #2;
        v     = 13'd8191;
        rst_n = 1'b0;
        #1;
        chk("rst_mid", int'(sv), 0, 0);
        @(posedge clk);
        #1;
        chk("rst_mid_hold", int'(sv), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        v     = 13'd4096;
        @(posedge clk);
        #1;
        chk("rst_release", int'(sv), 23172, 2);

        // Exhaustive sweep against the ideal sine.
        prev = 0;
        for (int i = 0; i < 8192; i++) begin
            drive(13'(i));
            cur = int'(sv);
            chk($sformatf("sweep v=%0d", i), cur, ideal(i), 2);
            chk($sformatf("msb v=%0d", i), int'(sv[15]), 0, 0);
            if (i > 0) begin
                chk($sformatf("mono v=%0d", i), (cur < prev) ? cur : prev, prev, 0);
            end
            prev = cur;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
